// File: rtl/shared_reg_pkg.sv
// rtl/shared_reg_pkg.sv - shared types, defaults and pointer-width helper for shared_reg_arbiter
// HOLD state exists only when SHARED_REG_LOCK_EN is defined.
package shared_reg_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
`ifdef SHARED_REG_LOCK_EN
    , HOLD = 2'd3
`endif
  } state_t;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rtl/shared_reg_arbiter_rr_pick.sv - round-robin pick of the first request at or after ptr
module rr_pick
  import shared_reg_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   index,
  output logic            valid
);

  // Walk distances from farthest to nearest so the nearest hit wins last.
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && (i == ((int'(ptr) + k) % NREQ))) begin
          index = PW'(i);
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin arbitrated shared write register
// Optional lock port and HOLD state enabled by SHARED_REG_LOCK_EN.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef SHARED_REG_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  localparam int PW = clog2(NREQ);

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic [PW-1:0]    owner_inc;
  logic [PW-1:0]    pick_idx;
  logic             pick_vld;
  logic [WIDTH-1:0] wsel;
  logic             owner_req;
`ifdef SHARED_REG_LOCK_EN
  logic             owner_lock;
`endif

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .index (pick_idx),
    .valid (pick_vld)
  );

  always_comb begin
    wsel      = '0;
    owner_req = 1'b0;
`ifdef SHARED_REG_LOCK_EN
    owner_lock = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (owner == PW'(i)) begin
        wsel      = wdata[i*WIDTH +: WIDTH];
        owner_req = req[i];
`ifdef SHARED_REG_LOCK_EN
        owner_lock = lock[i];
`endif
      end
    end
  end

  assign owner_inc = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

  // q loads on the edge entering WRITE, so ack is visible for the whole WRITE cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      q     <= '0;
      gnt   <= '0;
      ack   <= '0;
      busy  <= 1'b0;
    end else begin
      ack <= '0;
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            owner <= pick_idx;
            gnt   <= NREQ'(1) << pick_idx;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (owner_req) begin
            q     <= wsel;
            ack   <= gnt;
            state <= WRITE;
          end else begin
            gnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        WRITE: begin
          ptr <= owner_inc;
`ifdef SHARED_REG_LOCK_EN
          if (owner_lock) begin
            state <= HOLD;
          end else begin
            gnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
`else
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
`endif
        end
`ifdef SHARED_REG_LOCK_EN
        HOLD: begin
          if (!owner_lock) begin
            ptr   <= owner_inc;
            gnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (owner_req) begin
            q   <= wsel;
            ack <= gnt;
          end
        end
`endif
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - scoreboard bench for shared_reg_arbiter (lock scenario under SHARED_REG_LOCK_EN)
module tb_shared_reg_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
`ifdef SHARED_REG_LOCK_EN
  logic [NREQ-1:0]       lock;
`endif
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic                  busy;

  typedef struct packed {
    logic [NREQ-1:0]  ack;
    logic [WIDTH-1:0] q;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wdata (wdata),
`ifdef SHARED_REG_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .ack   (ack),
    .q     (q),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [NREQ-1:0] a, input logic [WIDTH-1:0] d);
    exp_t e;
    e.ack = a;
    e.q   = d;
    sb.push_back(e);
  endtask

  // Monitor: every ack pulse is matched against the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (ack != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=%b q=0x%0h, required no ack at %0t", ack, q, $time);
      end else begin
        e = sb.pop_front();
        check("ack", 32'(ack), 32'(e.ack));
        check("q_on_ack", 32'(q), 32'(e.q));
        check("gnt_on_ack", 32'(gnt), 32'(e.ack));
      end
    end
  end

  initial begin
    reset = 1'b0;
    req   = '0;
    wdata = '0;
`ifdef SHARED_REG_LOCK_EN
    lock  = '0;
`endif
    tick(2);
    reset = 1'b1;
    tick(1);
    check("reset_q", 32'(q), 32'h00);
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_ack", 32'(ack), 32'h0);

    // Single write from requester 0
    req = 4'b0001;
    wdata[0*WIDTH +: WIDTH] = 8'hA5;
    push(4'b0001, 8'hA5);
    tick(1);
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_busy", 32'(busy), 32'h1);
    tick(1);
    check("single_q", 32'(q), 32'hA5);
    req = '0;
    tick(1);
    check("single_idle_busy", 32'(busy), 32'h0);
    check("single_idle_gnt", 32'(gnt), 32'h0);

    // All requesting: order 0,1,2,3,0 from a fresh pointer
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    wdata = {8'h40, 8'h30, 8'h20, 8'h10};
    req   = 4'b1111;
    push(4'b0001, 8'h10);
    push(4'b0010, 8'h20);
    push(4'b0100, 8'h30);
    push(4'b1000, 8'h40);
    push(4'b0001, 8'h10);
    tick(14);
    req = '0;
    tick(2);
    check("rr_q_hold", 32'(q), 32'h10);
    check("rr_busy", 32'(busy), 32'h0);

    // Requester 2 drops during GRANT: no write, pointer stays at 1
    wdata = {8'h00, 8'hEE, 8'h00, 8'h00};
    req   = 4'b0100;
    tick(1);
    check("drop_gnt", 32'(gnt), 32'h4);
    req = '0;
    tick(1);
    check("drop_gnt_clear", 32'(gnt), 32'h0);
    check("drop_q_unchanged", 32'(q), 32'h10);
    wdata = {8'h00, 8'h5C, 8'h00, 8'h77};
    req   = 4'b0101;
    push(4'b0100, 8'h5C);
    push(4'b0001, 8'h77);
    tick(1);
    check("rereq_gnt", 32'(gnt), 32'h4);
    tick(4);
    req = '0;
    tick(2);
    check("pending_q", 32'(q), 32'h77);

    // Reset during GRANT aborts the write
    wdata = {8'h00, 8'h00, 8'hCC, 8'h00};
    req   = 4'b0010;
    tick(1);
    check("grant_abort_gnt", 32'(gnt), 32'h2);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    req   = '0;
    check("grant_abort_q", 32'(q), 32'h00);
    check("grant_abort_gnt0", 32'(gnt), 32'h0);
    tick(2);

    // Reset during WRITE clears q and ack
    wdata = {8'hFF, 8'h00, 8'h00, 8'h00};
    req   = 4'b1000;
    push(4'b1000, 8'hFF);
    tick(2);
    reset = 1'b0;
    tick(1);
    check("write_abort_q", 32'(q), 32'h00);
    check("write_abort_ack", 32'(ack), 32'h0);
    check("write_abort_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    req   = '0;
    tick(2);

`ifdef SHARED_REG_LOCK_EN
    // Locked ownership by requester 1 with three beats
    lock  = 4'b0010;
    req   = 4'b0010;
    wdata = {8'h00, 8'h00, 8'h11, 8'h99};
    push(4'b0010, 8'h11);
    tick(1);
    check("lock_gnt", 32'(gnt), 32'h2);
    req = 4'b0011;
    tick(1);
    wdata[1*WIDTH +: WIDTH] = 8'h22;
    push(4'b0010, 8'h22);
    tick(1);
    check("hold_gnt", 32'(gnt), 32'h2);
    check("hold_busy", 32'(busy), 32'h1);
    tick(1);
    wdata[1*WIDTH +: WIDTH] = 8'h33;
    push(4'b0010, 8'h33);
    tick(1);
    check("hold_blocks_req0", 32'(gnt), 32'h2);
    lock = '0;
    req  = 4'b0101;
    wdata[2*WIDTH +: WIDTH] = 8'h44;
    push(4'b0100, 8'h44);
    tick(1);
    check("unlock_idle_gnt", 32'(gnt), 32'h0);
    tick(1);
    check("unlock_next_gnt", 32'(gnt), 32'h4);
    tick(1);
    req = '0;
    tick(2);
`endif

    tick(2);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
